// File: rtl/hog_svm_block_mac.sv
// -----------------------------------------------------------------------------
// hog_svm_block_mac
//
// Partial SVM dot product for one normalized HOG block (2x2 cells, 36 features).
// A block is latched in IDLE, then 36 weights are fetched from an external
// synchronous weight memory (one read per cycle, address bid*36+idx). Each
// weight returns one cycle after its read strobe and is multiplied with the
// matching (delayed) feature and accumulated. The signed partial score is
// presented with the block id as a one-cycle o_valid pulse.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   clear           synchronous abort (frame start), returns to IDLE
//   bid             block id of the incoming block
//   fea_a..fea_d    9 unsigned features per cell, element k at [k*FEA_W +: FEA_W]
//   i_valid         single-cycle block strobe (no backpressure upstream)
//   i_ready         high only in IDLE
//   w_addr, w_rd    weight memory read address / strobe
//   w_data          weight, valid exactly one cycle after w_rd
//   o_bid, o_score  result block id / signed partial score (held until next result)
//   o_valid         one-cycle result pulse
//   err_drop        sticky: a block arrived while busy (cleared by rst/clear)
// -----------------------------------------------------------------------------
module hog_svm_block_mac #(
    parameter int BID_W = 13,
    parameter int FEA_I = 4,
    parameter int FEA_F = 28,
    parameter int W_I   = 4,
    parameter int W_F   = 12,
    parameter int ACC_W = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic [BID_W-1:0]              bid,
    input  logic [9*(FEA_I+FEA_F)-1:0]    fea_a,
    input  logic [9*(FEA_I+FEA_F)-1:0]    fea_b,
    input  logic [9*(FEA_I+FEA_F)-1:0]    fea_c,
    input  logic [9*(FEA_I+FEA_F)-1:0]    fea_d,
    input  logic                          i_valid,
    output logic                          i_ready,
    output logic [BID_W+5:0]              w_addr,
    output logic                          w_rd,
    input  logic [W_I+W_F-1:0]            w_data,
    output logic [BID_W-1:0]              o_bid,
    output logic [ACC_W-1:0]              o_score,
    output logic                          o_valid,
    output logic                          err_drop
);

    localparam int FEA_W  = FEA_I + FEA_F;
    localparam int W_W    = W_I + W_F;
    localparam int PROD_W = FEA_W + W_W + 1;
    localparam int ADDR_W = BID_W + 6;
    localparam int NFEA   = 36;
    localparam logic [5:0] IDX_LAST = 6'(NFEA - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                       state_q, state_d;
    logic [BID_W-1:0]             bid_q;
    logic [NFEA*FEA_W-1:0]        fea_q;       // {d, c, b, a}: idx order a0..a8, b0..b8, ...
    logic [5:0]                   idx_q;
    logic [FEA_W-1:0]             feat_dly_q;  // feature aligned with the returning weight
    logic                         rd_dly_q;    // w_data is valid this cycle
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [ACC_W-1:0]             o_score_q;
    logic [BID_W-1:0]             o_bid_q;
    logic                         o_valid_q;
    logic                         err_q;

    logic                         accept, drop;
    logic [FEA_W-1:0]             fea_sel;
    logic [ADDR_W-1:0]            addr;
    logic signed [PROD_W-1:0]     fea_ext, w_ext, prod;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (i_valid) state_d = RUN;
                RUN:     if (idx_q == IDX_LAST) state_d = DRAIN;
                DRAIN:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        i_ready = (state_q == IDLE);
        w_rd    = (state_q == RUN);
        w_addr  = w_rd ? addr : '0;
        accept  = i_valid && !clear && (state_q == IDLE);
        drop    = i_valid && !clear && (state_q != IDLE);
    end

    // ---------------------------------------------------------------- datapath
    assign fea_sel = fea_q[idx_q*FEA_W +: FEA_W];
    assign addr    = ADDR_W'(bid_q) * ADDR_W'(NFEA) + ADDR_W'(idx_q);

    // Feature is unsigned (zero-extend), weight is two's complement (sign-extend).
    // Both are widened to the full product width so the multiply is exact.
    assign fea_ext = $signed({{(PROD_W-FEA_W){1'b0}}, feat_dly_q});
    assign w_ext   = $signed({{(PROD_W-W_W){w_data[W_W-1]}}, w_data});
    assign prod    = fea_ext * w_ext;
    assign acc_d   = acc_q + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});

    always_ff @(posedge clk) begin
        if (rst) begin
            bid_q      <= '0;
            fea_q      <= '0;
            idx_q      <= '0;
            feat_dly_q <= '0;
            rd_dly_q   <= 1'b0;
            acc_q      <= '0;
            o_score_q  <= '0;
            o_bid_q    <= '0;
            o_valid_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            feat_dly_q <= fea_sel;
            rd_dly_q   <= w_rd && !clear;
            // Result is registered on leaving DRAIN so it appears together
            // with o_valid during DONE.
            o_valid_q  <= (state_q == DRAIN) && !clear;
            if (clear) begin
                idx_q <= '0;
                err_q <= 1'b0;
            end else begin
                if (drop) err_q <= 1'b1;
                if (accept) begin
                    bid_q <= bid;
                    fea_q <= {fea_d, fea_c, fea_b, fea_a};
                    idx_q <= '0;
                    acc_q <= '0;
                end else begin
                    if (state_q == RUN) idx_q <= (idx_q == IDX_LAST) ? 6'd0 : idx_q + 6'd1;
                    if (rd_dly_q) acc_q <= acc_d;
                end
                if (state_q == DRAIN) begin
                    o_score_q <= acc_d;
                    o_bid_q   <= bid_q;
                end
            end
        end
    end

    assign o_score  = o_score_q;
    assign o_bid    = o_bid_q;
    assign o_valid  = o_valid_q;
    assign err_drop = err_q;

endmodule

// File: tb/tb_hog_svm_block_mac.sv
// -----------------------------------------------------------------------------
// tb_hog_svm_block_mac
//
// Directed bench for hog_svm_block_mac. A behavioural weight memory answers
// each read one cycle later with a weight chosen by wmode from the address
// (addr % 36 is the feature index); when not reading it drives junk so any
// out-of-window sampling shows up in the score. Expected scores are
// hand-computed in Q(.40) units (feature Q.28 times weight Q.12).
// -----------------------------------------------------------------------------
module tb_hog_svm_block_mac;

    localparam int FW = 32;

    logic                 clk = 1'b0;
    logic                 rst, clear, i_valid;
    logic [12:0]          bid;
    logic [9*FW-1:0]      fea_a, fea_b, fea_c, fea_d;
    logic                 i_ready, w_rd, o_valid, err_drop;
    logic [18:0]          w_addr;
    logic [15:0]          w_data;
    logic [12:0]          o_bid;
    logic [63:0]          o_score;

    int checks = 0;
    int errors = 0;
    int wmode  = 0;

    hog_svm_block_mac dut (
        .clk(clk), .rst(rst), .clear(clear), .bid(bid),
        .fea_a(fea_a), .fea_b(fea_b), .fea_c(fea_c), .fea_d(fea_d),
        .i_valid(i_valid), .i_ready(i_ready), .w_addr(w_addr), .w_rd(w_rd),
        .w_data(w_data), .o_bid(o_bid), .o_score(o_score), .o_valid(o_valid),
        .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] wt(input int idx);
        case (wmode)
            0: wt = 16'h1000;                                   // +1.0
            1: wt = (idx % 2 == 0) ? 16'hF000 : 16'h0800;       // -1.0 / +0.5
            2: wt = (idx < 9) ? 16'h1000 : (idx < 18) ? 16'h2000 :
                    (idx < 27) ? 16'hF000 : 16'h3000;           // 1, 2, -1, 3 per cell
            default: wt = 16'h8000;                             // -8.0
        endcase
    endfunction

    always @(posedge clk) begin
        if (w_rd) w_data <= wt(int'(w_addr % 19'd36));
        else      w_data <= 16'hA5A5;
    end

    function automatic logic [36*FW-1:0] mkfea(input logic [31:0] a, b, c, d);
        logic [36*FW-1:0] f;
        for (int k = 0; k < 36; k++)
            f[k*FW +: FW] = (k < 9) ? a : (k < 18) ? b : (k < 27) ? c : d;
        return f;
    endfunction

    // Issues one block in the current cycle (T) and walks T+1..T+39, or stops
    // one cycle after an injected clear/reset. Reports address mismatches,
    // number of o_valid pulses, cycle offset of the last pulse and its payload.
    task automatic run_block(input logic [12:0] b, input logic [36*FW-1:0] f,
                             input int inj_c, input int clr_c, input int rst_c,
                             output int bad_addr, output int nvalid, output int vcyc,
                             output logic [63:0] sc, output logic [12:0] ob);
        logic stop;
        logic exp_rd;
        stop = 1'b0;
        bad_addr = 0; nvalid = 0; vcyc = -1; sc = '0; ob = '0;
        bid = b;
        {fea_d, fea_c, fea_b, fea_a} = f;
        i_valid = 1'b1;
        for (int c = 1; c <= 39 && !stop; c++) begin
            @(posedge clk); #1;
            i_valid = (c == inj_c);
            if (c == inj_c) bid = b + 13'd1;
            clear = (c == clr_c);
            rst   = (c == rst_c);
            exp_rd = (c <= 36) && !(clr_c > 0 && c > clr_c) && !(rst_c > 0 && c > rst_c);
            if (w_rd !== exp_rd || (exp_rd && w_addr !== 19'(b) * 19'd36 + 19'(c - 1)))
                bad_addr++;
            if (o_valid) begin nvalid++; vcyc = c; sc = o_score; ob = o_bid; end
            if ((clr_c > 0 && c == clr_c + 1) || (rst_c > 0 && c == rst_c + 1)) stop = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; i_valid = 1'b0; bid = '0;
        fea_a = '0; fea_b = '0; fea_c = '0; fea_d = '0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        checks++; if (o_valid !== 1'b0 || w_rd !== 1'b0 || err_drop !== 1'b0) begin errors++; $display("FAIL reset_ctl: o_valid=%b w_rd=%b err_drop=%b required 0", o_valid, w_rd, err_drop); end
        checks++; if (o_score !== 64'd0 || o_bid !== 13'd0 || w_addr !== 19'd0) begin errors++; $display("FAIL reset_data: score=%0h bid=%0d addr=%0d required 0", o_score, o_bid, w_addr); end
        checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", i_ready); end
    endtask

    task automatic test_single();
        int ba, nv, vc; logic [63:0] sc; logic [12:0] ob;
        wmode = 0;
        run_block(13'd5, mkfea(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000), 0, 0, 0, ba, nv, vc, sc, ob);
        checks++; if (ba !== 0) begin errors++; $display("FAIL single_addr: %0d bad cycles required 0", ba); end
        checks++; if (nv !== 1 || vc !== 38) begin errors++; $display("FAIL single_valid: pulses=%0d at T+%0d required 1 at T+38", nv, vc); end
        checks++; if (sc !== (64'd36 << 40) || ob !== 13'd5) begin errors++; $display("FAIL single_score: score=%0h bid=%0d required %0h bid 5", sc, ob, 64'd36 << 40); end
        checks++; if (i_ready !== 1'b1 || o_valid !== 1'b0 || o_score !== (64'd36 << 40)) begin errors++; $display("FAIL single_after: ready=%b valid=%b score=%0h required 1 0 held", i_ready, o_valid, o_score); end
    endtask

    task automatic test_signed();
        int ba, nv, vc; logic [63:0] sc; logic [12:0] ob;
        // 18 x (-1.0) + 18 x (+0.5) = -9.0
        wmode = 1;
        run_block(13'd77, mkfea(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000), 0, 0, 0, ba, nv, vc, sc, ob);
        checks++; if (ba !== 0 || nv !== 1 || vc !== 38) begin errors++; $display("FAIL signed_timing: bad=%0d pulses=%0d at T+%0d required 0 1 38", ba, nv, vc); end
        checks++; if (sc !== 64'(-(64'sd9 <<< 40)) || ob !== 13'd77) begin errors++; $display("FAIL signed_score: score=%0h bid=%0d required %0h bid 77", sc, ob, 64'(-(64'sd9 <<< 40))); end
    endtask

    task automatic test_order();
        int ba, nv, vc; logic [63:0] sc; logic [12:0] ob;
        // a=1.0*w1.0, b=2.0*w2.0, c=0*w-1.0, d=0.5*w3.0 -> 9*(1+4+0+1.5) = 58.5
        wmode = 2;
        run_block(13'd100, mkfea(32'h1000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0800_0000), 0, 0, 0, ba, nv, vc, sc, ob);
        checks++; if (sc !== (64'd117 << 39) || nv !== 1) begin errors++; $display("FAIL order_score: score=%0h pulses=%0d required %0h 1", sc, nv, 64'd117 << 39); end
        // max feature times most negative weight on every element
        wmode = 3;
        run_block(13'd1, mkfea(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 0, 0, 0, ba, nv, vc, sc, ob);
        checks++; if (sc !== 64'(-64'sd36 * 64'sd4294967295 * 64'sd32768)) begin errors++; $display("FAIL extreme_score: score=%0h required %0h", sc, 64'(-64'sd36 * 64'sd4294967295 * 64'sd32768)); end
    endtask

    task automatic test_busy_drop();
        int ba, nv, vc; logic [63:0] sc; logic [12:0] ob;
        wmode = 0;
        run_block(13'd7, mkfea(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000), 10, 0, 0, ba, nv, vc, sc, ob);
        checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_flag: got %b required 1", err_drop); end
        checks++; if (ba !== 0 || nv !== 1 || sc !== (64'd36 << 40) || ob !== 13'd7) begin errors++; $display("FAIL drop_result: bad=%0d pulses=%0d score=%0h bid=%0d required 0 1 %0h 7", ba, nv, sc, ob, 64'd36 << 40); end
        // accepted normally at T+39; err_drop stays sticky
        run_block(13'd9, mkfea(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000), 0, 0, 0, ba, nv, vc, sc, ob);
        checks++; if (ba !== 0 || vc !== 38 || ob !== 13'd9 || sc !== (64'd36 << 40)) begin errors++; $display("FAIL drop_next: bad=%0d at T+%0d bid=%0d score=%0h required 0 38 9 %0h", ba, vc, ob, sc, 64'd36 << 40); end
        checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b required 1", err_drop); end
    endtask

    task automatic test_clear();
        int ba, nv, vc; logic [63:0] sc; logic [12:0] ob;
        wmode = 0;
        run_block(13'd3, mkfea(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000), 0, 20, 0, ba, nv, vc, sc, ob);
        checks++; if (ba !== 0 || nv !== 0) begin errors++; $display("FAIL clear_stop: bad=%0d pulses=%0d required 0 0", ba, nv); end
        checks++; if (err_drop !== 1'b0 || o_score !== (64'd36 << 40) || o_bid !== 13'd9) begin errors++; $display("FAIL clear_state: err=%b score=%0h bid=%0d required 0 held 9", err_drop, o_score, o_bid); end
        wmode = 1;
        run_block(13'd11, mkfea(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000), 0, 0, 0, ba, nv, vc, sc, ob);
        checks++; if (ba !== 0 || vc !== 38 || ob !== 13'd11 || sc !== 64'(-(64'sd9 <<< 40))) begin errors++; $display("FAIL clear_next: bad=%0d at T+%0d bid=%0d score=%0h", ba, vc, ob, sc); end
        // clear and i_valid together: block must not be accepted
        clear = 1'b1; i_valid = 1'b1; bid = 13'd2;
        @(posedge clk); #1;
        clear = 1'b0; i_valid = 1'b0;
        checks++; if (w_rd !== 1'b0 || i_ready !== 1'b1) begin errors++; $display("FAIL clear_wins: w_rd=%b ready=%b required 0 1", w_rd, i_ready); end
    endtask

    task automatic test_back_to_back();
        int ba0, nv0, vc0, ba1, nv1, vc1; logic [63:0] sc0, sc1; logic [12:0] ob0, ob1;
        wmode = 0;
        run_block(13'd0, mkfea(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000), 0, 0, 0, ba0, nv0, vc0, sc0, ob0);
        checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b required 1", i_ready); end
        run_block(13'd8191, mkfea(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000), 0, 0, 0, ba1, nv1, vc1, sc1, ob1);
        checks++; if (ba0 !== 0 || ba1 !== 0) begin errors++; $display("FAIL b2b_addr: bad0=%0d bad1=%0d required 0 0", ba0, ba1); end
        // second block issued 39 cycles after the first, both pulses at +38
        checks++; if (nv0 !== 1 || nv1 !== 1 || vc0 !== 38 || vc1 !== 38) begin errors++; $display("FAIL b2b_valid: %0d@%0d %0d@%0d required 1@38 1@38", nv0, vc0, nv1, vc1); end
        checks++; if (ob0 !== 13'd0 || ob1 !== 13'd8191 || sc1 !== (64'd36 << 40)) begin errors++; $display("FAIL b2b_result: bid0=%0d bid1=%0d score1=%0h", ob0, ob1, sc1); end
    endtask

    task automatic test_reset_mid();
        int ba, nv, vc, late; logic [63:0] sc; logic [12:0] ob;
        wmode = 0;
        run_block(13'd4, mkfea(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000), 0, 0, 30, ba, nv, vc, sc, ob);
        checks++; if (ba !== 0 || nv !== 0) begin errors++; $display("FAIL rstmid_stop: bad=%0d pulses=%0d required 0 0", ba, nv); end
        checks++; if (o_score !== 64'd0 || o_bid !== 13'd0 || err_drop !== 1'b0 || w_addr !== 19'd0 || i_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state: score=%0h bid=%0d err=%b addr=%0d ready=%b", o_score, o_bid, err_drop, w_addr, i_ready); end
        late = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (o_valid || w_rd) late++;
        end
        checks++; if (late !== 0) begin errors++; $display("FAIL rstmid_quiet: %0d active cycles required 0", late); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_signed();
        test_order();
        test_busy_drop();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
